shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/mult_pkg.sv | 14 +
 rtl/cla_adder.sv | 41 ++++
 rtl/shift_add_mult.sv | 127 ++++++++++++
 tb/tb_shift_add_mult.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared state encoding and sizing constants for the shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MULT_N = 32;
    // Six bits count to 63, enough for the widest legal operand (64 bits).
    localparam int CNT_W  = 6;

endpackage

// File: rtl/cla_adder.sv
// N-bit carry-lookahead adder (parallel-prefix carries); purely combinational.
// Latency: 0 cycles; no flow control.
module cla_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    // Kogge-Stone prefix tree; cin is folded into bit 0's generate term.
    function automatic logic [N:0] prefix_add(input logic [N-1:0] a,
                                              input logic [N-1:0] b,
                                              input logic         cin);
        logic [N-1:0] p0;
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] gn;
        logic [N-1:0] pn;
        p0   = a ^ b;
        g    = a & b;
        g[0] = g[0] | (p0[0] & cin);
        p    = p0;
        for (int d = 1; d < N; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < N; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        return {g[N-1], p0 ^ {g[N-2:0], cin}};
    endfunction

    assign {cout_o, sum_o} = prefix_add(a_i, b_i, cin_i);

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle; ZERO_SKIP_EN shortcuts zero operands.
// Latency: resp_valid N edges after accept (1 with zero skip); product held until resp_ready, abort cancels.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic           abort,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       mcand_q, mcand_d;
    logic [2*N-1:0]     acc_q, acc_d;
    logic [2*N-1:0]     product_q, product_d;

    logic               accept;
    logic               skip;
    logic               calc_last;
    logic [N-1:0]       addend;
    logic [N-1:0]       sum;
    logic               cout;
    logic [2*N-1:0]     acc_step;

    assign accept    = (state_q == IDLE) && req_valid;
    assign calc_last = (cnt_q == LAST);

`ifdef ZERO_SKIP_EN
    assign skip = (a_in == '0) || (b_in == '0);
`else
    assign skip = 1'b0;
`endif

    assign addend = acc_q[0] ? mcand_q : '0;

    cla_adder #(.N(N)) u_adder (
        .a_i    (acc_q[2*N-1:N]),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Carry-out becomes the new MSB while the consumed multiplier bit drops off the bottom.
    assign acc_step = {cout, sum, acc_q[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (req_valid)  state_d = skip ? DONE : CALC;
                CALC:    if (calc_last)  state_d = DONE;
                DONE:    if (resp_ready) state_d = IDLE;
                default:                 state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q == CALC);
        resp_valid = (state_q == DONE);
        product    = product_q;
    end

    // Abort freezes the datapath so acc and product keep their last values.
    always_comb begin
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        if (!abort) begin
            if (accept) begin
                mcand_d = a_in;
                acc_d   = {{N{1'b0}}, b_in};
                cnt_d   = '0;
                if (skip) begin
                    acc_d     = '0;
                    product_d = '0;
                end
            end else if (state_q == CALC) begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (calc_last) begin
                    product_d = acc_step;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: transaction-level model checked every cycle, directed corners, random traffic.
// Honours ZERO_SKIP_EN when defined at build time.
module tb_shift_add_mult;

    localparam int N   = 8;
    localparam int W2  = 2 * N;
    localparam int N32 = 32;
`ifdef ZERO_SKIP_EN
    localparam int ZLAT  = 1;
    localparam bit ZSKIP = 1'b1;
`else
    localparam int ZLAT  = N;
    localparam bit ZSKIP = 1'b0;
`endif
    localparam int PH_IDLE = 0;
    localparam int PH_CALC = 1;
    localparam int PH_DONE = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            req_valid, abort, resp_ready;
    logic [N-1:0]    a_in, b_in;
    logic            req_ready, resp_valid, busy;
    logic [W2-1:0]   product;

    logic             q_req_valid, q_abort, q_resp_ready;
    logic [N32-1:0]   q_a, q_b;
    logic             q_req_ready, q_resp_valid, q_busy;
    logic [2*N32-1:0] q_product;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    shift_add_mult #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .abort      (abort),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .product    (product),
        .busy       (busy)
    );

    shift_add_mult #(.N(N32)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (q_req_valid),
        .req_ready  (q_req_ready),
        .a_in       (q_a),
        .b_in       (q_b),
        .abort      (q_abort),
        .resp_valid (q_resp_valid),
        .resp_ready (q_resp_ready),
        .product    (q_product),
        .busy       (q_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted pair is answered with a*b after N cycles (or 1 for skipped zeros).
    int            m_phase;
    int            m_left;
    int            m_accepts = 0;
    logic [W2-1:0] m_pend;
    logic [W2-1:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= PH_IDLE;
            m_left  <= 0;
            m_prod  <= '0;
        end else if (abort) begin
            m_phase <= PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE: if (req_valid) begin
                    m_accepts <= m_accepts + 1;
                    m_pend    <= W2'(a_in) * W2'(b_in);
                    if (ZSKIP && (a_in == '0 || b_in == '0)) begin
                        m_phase <= PH_DONE;
                        m_prod  <= '0;
                    end else begin
                        m_phase <= PH_CALC;
                        m_left  <= N;
                    end
                end
                PH_CALC: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= PH_DONE;
                        m_prod  <= m_pend;
                    end
                end
                PH_DONE: if (resp_ready) m_phase <= PH_IDLE;
                default: m_phase <= PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_req_ready",  64'(req_ready),  64'(m_phase == PH_IDLE));
            chk("cyc_resp_valid", 64'(resp_valid), 64'(m_phase == PH_DONE));
            chk("cyc_busy",       64'(busy),       64'(m_phase == PH_CALC));
            chk("cyc_product",    64'(product),    64'(m_prod));
        end
    end

    function automatic logic [N-1:0] pick();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return N'($urandom);
    endfunction

    // Called on a negedge while idle; returns cycles from the accept edge to resp_valid.
    task automatic run_req(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
        req_valid = 1'b1;
        a_in      = a;
        b_in      = b;
        @(negedge clk);
        req_valid = 1'b0;
        a_in      = N'($urandom);
        b_in      = N'($urandom);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int target;
        req_valid = 1'b0; abort = 1'b0; resp_ready = 1'b1; a_in = '0; b_in = '0;
        q_req_valid = 1'b0; q_abort = 1'b0; q_resp_ready = 1'b1; q_a = '0; q_b = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_req_ready",  64'(req_ready),  64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_product",    64'(product),    64'd0);
        chk("rst32_product",  q_product,       64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 32-bit worst case
        q_req_valid = 1'b1; q_a = '1; q_b = '1;
        @(negedge clk);
        q_req_valid = 1'b0; q_a = '0; q_b = '0;
        lat = 0;
        while (!q_resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("n32_latency", 64'(lat), 64'd32);
        chk("n32_product", q_product, 64'hFFFFFFFE00000001);
        @(negedge clk);

        run_req(8'd13, 8'd11, lat);
        chk("13x11_latency", 64'(lat), 64'd8);
        chk("13x11_product", 64'(product), 64'd143);
        @(negedge clk);
        chk("13x11_ready_after", 64'(req_ready), 64'd1);
        chk("13x11_valid_after", 64'(resp_valid), 64'd0);

        run_req(8'd255, 8'd255, lat);
        chk("255x255_latency", 64'(lat), 64'd8);
        chk("255x255_product", 64'(product), 64'd65025);
        @(negedge clk);

        run_req(8'd0, 8'd200, lat);
        chk("0x200_latency", 64'(lat), 64'(ZLAT));
        chk("0x200_product", 64'(product), 64'd0);
        @(negedge clk);

        // Backpressure: held result, stray requests ignored
        resp_ready = 1'b0;
        run_req(8'd100, 8'd3, lat);
        chk("stall_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 20; i++) begin
            req_valid = i[0];
            a_in      = pick();
            b_in      = pick();
            @(negedge clk);
            chk("stall_valid",   64'(resp_valid), 64'd1);
            chk("stall_product", 64'(product),    64'd300);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 64'(resp_valid), 64'd0);
        chk("stall_release_ready", 64'(req_ready),  64'd1);

        // Abort beats a same-cycle accept
        req_valid = 1'b1; abort = 1'b1; a_in = 8'd5; b_in = 8'd5;
        @(negedge clk);
        req_valid = 1'b0; abort = 1'b0;
        chk("abort_accept_ready", 64'(req_ready), 64'd1);
        chk("abort_accept_busy",  64'(busy),      64'd0);

        // Abort in the fourth CALC cycle
        req_valid = 1'b1; a_in = 8'd50; b_in = 8'd60;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready",   64'(req_ready),  64'd1);
        chk("abort_valid",   64'(resp_valid), 64'd0);
        chk("abort_product", 64'(product),    64'd300);
        repeat (10) @(negedge clk);
        chk("abort_no_resp", 64'(resp_valid), 64'd0);
        run_req(8'd7, 8'd9, lat);
        chk("abort_7x9_latency", 64'(lat), 64'd8);
        chk("abort_7x9_product", 64'(product), 64'd63);
        @(negedge clk);

        // Reset in the third CALC cycle
        req_valid = 1'b1; a_in = 8'd20; b_in = 8'd30;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready",   64'(req_ready),  64'd1);
        chk("midrst_busy",    64'(busy),       64'd0);
        chk("midrst_valid",   64'(resp_valid), 64'd0);
        chk("midrst_product", 64'(product),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(8'd7, 8'd9, lat);
        chk("rst_7x9_latency", 64'(lat), 64'd8);
        chk("rst_7x9_product", 64'(product), 64'd63);
        @(negedge clk);

        // Random traffic with backpressure and occasional aborts
        target = m_accepts + 3000;
        cyc = 0;
        while (m_accepts < target && cyc < 60000) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            a_in       = pick();
            b_in       = pick();
            resp_ready = 1'($urandom_range(0, 1));
            abort      = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0; abort = 1'b0; resp_ready = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("final_idle", 64'(req_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
